// File: rtl/lcg_pkg.sv
// Shared types and helpers for the LCG seed search: FSM state encoding,
// a constant-foldable clog2, and the fixed latency of one LCG step.
package lcg_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   // Cycles from go to valid: one-bit restoring reduction over the 2W+1-bit sum.
   function automatic int unsigned step_latency(input int unsigned w, input bit mod_en);
      return mod_en ? (2 * w + 1) : 1;
   endfunction

endpackage

// File: rtl/lcg_seed_search_if.sv
// Host-side control/operand/result bundle for lcg_seed_search.
interface lcg_seed_search_if #(
   parameter int unsigned W     = 32,
   parameter int unsigned N_MAX = 4
) ();
   localparam int unsigned NW = lcg_pkg::clog2(N_MAX + 1);

   logic                 start;
   logic                 abort;
   logic [W-1:0]         modulus;
   logic [W-1:0]         multiplier;
   logic [W-1:0]         increment;
   logic [W-1:0]         seed_lo;
   logic [W-1:0]         seed_hi;
   logic [NW-1:0]        num_expected;
   logic [N_MAX*W-1:0]   expected;
   logic                 busy;
   logic                 done;
   logic                 found;
   logic [W-1:0]         valid_seed;
   logic [W-1:0]         attempts;

   modport master (
      output start, abort, modulus, multiplier, increment, seed_lo, seed_hi,
      output num_expected, expected,
      input  busy, done, found, valid_seed, attempts
   );

   modport slave (
      input  start, abort, modulus, multiplier, increment, seed_lo, seed_hi,
      input  num_expected, expected,
      output busy, done, found, valid_seed, attempts
   );

endinterface

// File: rtl/lcg_step.sv
// One LCG step r = (x*a + c) mod m (or mod 2^W) with fixed latency.
// A go while a reduction is in flight restarts it with the new operands.
module lcg_step
   import lcg_pkg::*;
#(
   parameter int unsigned W      = 32,
   parameter bit          MOD_EN = 1'b1
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [W-1:0] x,
   input  logic [W-1:0] a,
   input  logic [W-1:0] c,
   input  logic [W-1:0] m,
   input  logic         go,
   output logic [W-1:0] r,
   output logic         valid
);
   localparam int unsigned PW = 2 * W + 1;
   localparam int unsigned L  = step_latency(W, MOD_EN);

   logic [PW-1:0] w_sum;
   logic [W-1:0]  r_res;
   logic          r_vld;

   assign w_sum = PW'(x) * PW'(a) + PW'(c);
   assign r     = r_res;
   assign valid = r_vld;

   function automatic logic [W-1:0] rstep(input logic [W-1:0] rem, input logic b,
                                         input logic [W-1:0] mod);
      logic [W:0] t;
      t = {rem, b};
      if (t >= {1'b0, mod}) t = t - {1'b0, mod};
      return t[W-1:0];
   endfunction

   if (MOD_EN) begin : g_mod
      localparam int unsigned CW = clog2(L + 1);

      logic [PW-1:0] r_div;
      logic [CW-1:0] r_cnt;

      // The go edge already consumes the MSB, so L edges cover all PW bits.
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_res <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
         end else begin
            r_vld <= 1'b0;
            if (go) begin
               r_res <= rstep('0, w_sum[PW-1], m);
               r_div <= w_sum << 1;
               r_cnt <= CW'(L - 1);
            end else if (r_cnt != '0) begin
               r_res <= rstep(r_res, r_div[PW-1], m);
               r_div <= r_div << 1;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) r_vld <= 1'b1;
            end
         end
      end
   end else begin : g_wrap
      logic w_unused;
      assign w_unused = ^{m, w_sum[PW-1:W]};

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            r_res <= '0;
            r_vld <= 1'b0;
         end else begin
            r_vld <= go;
            if (go) r_res <= w_sum[W-1:0];
         end
      end
   end

endmodule

// File: rtl/lcg_seed_search.sv
// Scans [seed_lo, seed_hi] for the first seed whose next NUM LCG outputs match
// the expected values; one step at a time, abandoning a seed on first mismatch.
module lcg_seed_search
   import lcg_pkg::*;
#(
   parameter int unsigned W      = 32,
   parameter int unsigned N_MAX  = 4,
   parameter bit          MOD_EN = 1'b1
) (
   input logic               CLK,
   input logic               RST_N,
   lcg_seed_search_if.slave  bus
);
   localparam int unsigned NW = clog2(N_MAX + 1);
   localparam int unsigned KW = (N_MAX > 1) ? clog2(N_MAX) : 1;

   state_e             r_state;
   logic [W-1:0]       r_m, r_a, r_c;
   logic [W-1:0]       r_seed, r_last;
   logic [N_MAX*W-1:0] r_expected;
   logic [KW-1:0]      r_k, r_k_last;
   logic               r_busy, r_done, r_found;
   logic [W-1:0]       r_valid_seed, r_attempts;

   logic [KW-1:0]      w_num_last;
   logic [W-1:0]       w_x, w_r, w_exp;
   logic               w_go, w_valid, w_abort;

   always_comb begin
      w_num_last = '0;
      if (bus.num_expected == '0) w_num_last = '0;
      else if (bus.num_expected > NW'(N_MAX)) w_num_last = KW'(N_MAX - 1);
      else w_num_last = KW'(bus.num_expected - 1'b1);
   end

   assign w_abort = bus.abort && (r_state != StIdle);
   assign w_go    = (r_state == StIssue) && !bus.abort;
   assign w_x     = (r_k == '0) ? r_seed : w_r;
   assign w_exp   = r_expected[r_k*W +: W];

   lcg_step #(
      .W      (W),
      .MOD_EN (MOD_EN)
   ) u_step (
      .CLK   (CLK),
      .RST_N (RST_N),
      .x     (w_x),
      .a     (r_a),
      .c     (r_c),
      .m     (r_m),
      .go    (w_go),
      .r     (w_r),
      .valid (w_valid)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state      <= StIdle;
         r_m          <= '0;
         r_a          <= '0;
         r_c          <= '0;
         r_seed       <= '0;
         r_last       <= '0;
         r_expected   <= '0;
         r_k          <= '0;
         r_k_last     <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_valid_seed <= '0;
         r_attempts   <= '0;
      end else if (w_abort) begin
         r_state      <= StIdle;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_found      <= 1'b0;
         r_valid_seed <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (bus.start) begin
                  r_m          <= bus.modulus;
                  r_a          <= bus.multiplier;
                  r_c          <= bus.increment;
                  r_seed       <= bus.seed_lo;
                  // An inverted range degenerates to the single seed seed_lo.
                  r_last       <= (bus.seed_lo > bus.seed_hi) ? bus.seed_lo : bus.seed_hi;
                  r_expected   <= bus.expected;
                  r_k          <= '0;
                  r_k_last     <= w_num_last;
                  r_attempts   <= '0;
                  r_busy       <= 1'b1;
                  r_found      <= 1'b0;
                  r_valid_seed <= '0;
                  r_state      <= StIssue;
               end
            end
            StIssue: r_state <= StWait;
            StWait: begin
               if (w_valid) begin
                  if (w_r == w_exp && r_k == r_k_last) begin
                     r_attempts   <= r_attempts + 1'b1;
                     r_found      <= 1'b1;
                     r_valid_seed <= r_seed;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_state      <= StDone;
                  end else if (w_r == w_exp) begin
                     r_k     <= r_k + 1'b1;
                     r_state <= StIssue;
                  end else begin
                     r_attempts <= r_attempts + 1'b1;
                     r_k        <= '0;
                     if (r_seed == r_last) begin
                        r_found      <= 1'b0;
                        r_valid_seed <= '0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= StDone;
                     end else begin
                        r_seed  <= r_seed + 1'b1;
                        r_state <= StIssue;
                     end
                  end
               end
            end
            StDone: begin
               r_done  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.found      = r_found;
   assign bus.valid_seed = r_valid_seed;
   assign bus.attempts   = r_attempts;

endmodule

// File: tb/tb_lcg_seed_search.sv
// Runs a wrap-mode and a true-modulus instance side by side on shared stimulus;
// a reference search model fills per-instance result queues checked on done.
module tb_lcg_seed_search;
   typedef struct packed {
      logic        found;
      logic [31:0] seed;
      logic [31:0] att;
      logic [31:0] cyc;
   } res_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [31:0]  m = '0, a = '0, c = '0, lo = '0, hi = '0;
   logic [2:0]   num = '0;
   logic [127:0] exp_v = '0;

   int errors = 0, checks = 0, cyc = 0, start_cyc = 0, dn0 = 0, dn1 = 0, d0 = 0, d1 = 0;
   res_t q0[$], q1[$];

   always #5 clk = ~clk;

   lcg_seed_search_if #(.W(32), .N_MAX(4)) u_if0 ();
   lcg_seed_search_if #(.W(32), .N_MAX(4)) u_if1 ();

   assign u_if0.start = start;        assign u_if1.start = start;
   assign u_if0.abort = abort;        assign u_if1.abort = abort;
   assign u_if0.modulus = m;          assign u_if1.modulus = m;
   assign u_if0.multiplier = a;       assign u_if1.multiplier = a;
   assign u_if0.increment = c;        assign u_if1.increment = c;
   assign u_if0.seed_lo = lo;         assign u_if1.seed_lo = lo;
   assign u_if0.seed_hi = hi;         assign u_if1.seed_hi = hi;
   assign u_if0.num_expected = num;   assign u_if1.num_expected = num;
   assign u_if0.expected = exp_v;     assign u_if1.expected = exp_v;

   lcg_seed_search #(.W(32), .N_MAX(4), .MOD_EN(1'b0)) u_dut0 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (u_if0)
   );

   lcg_seed_search #(.W(32), .N_MAX(4), .MOD_EN(1'b1)) u_dut1 (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (u_if1)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Brute-force reference search with 64-bit arithmetic; cyc = (L+1) per step.
   function automatic res_t model(input bit mod_en);
      res_t            r;
      longint unsigned s, last, v;
      int              n, lat;
      bit              ok;
      r    = '0;
      n    = (num == 0) ? 1 : ((num > 4) ? 4 : int'(num));
      lat  = mod_en ? 65 : 1;
      last = (lo > hi) ? 64'(lo) : 64'(hi);
      for (s = 64'(lo); s <= last; s++) begin
         v  = s;
         ok = 1'b1;
         for (int k = 0; k < n; k++) begin
            v = v * 64'(a) + 64'(c);
            v = mod_en ? (v % 64'(m)) : (v & 64'hFFFF_FFFF);
            r.cyc = r.cyc + 32'(lat) + 1;
            if (v[31:0] != exp_v[k*32 +: 32]) begin
               ok = 1'b0;
               break;
            end
         end
         r.att = r.att + 1;
         if (ok) begin
            r.found = 1'b1;
            r.seed  = s[31:0];
            break;
         end
      end
      return r;
   endfunction

   task automatic tick();
      res_t e;
      logic dn;
      int   qs;
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
         dn = (d == 1) ? u_if1.done : u_if0.done;
         if (dn) begin
            qs = (d == 1) ? q1.size() : q0.size();
            if (d == 1) dn1++; else dn0++;
            check_eq($sformatf("dut%0d_done_expected", d), 64'(dn), 64'(qs != 0));
            if (qs != 0) begin
               if (d == 1) e = q1.pop_front(); else e = q0.pop_front();
               check_eq($sformatf("dut%0d_found", d),
                        64'((d == 1) ? u_if1.found : u_if0.found), 64'(e.found));
               check_eq($sformatf("dut%0d_valid_seed", d),
                        64'((d == 1) ? u_if1.valid_seed : u_if0.valid_seed), 64'(e.seed));
               check_eq($sformatf("dut%0d_attempts", d),
                        64'((d == 1) ? u_if1.attempts : u_if0.attempts), 64'(e.att));
               check_eq($sformatf("dut%0d_done_latency", d), 64'(cyc - start_cyc), 64'(e.cyc));
               check_eq($sformatf("dut%0d_busy_at_done", d),
                        64'((d == 1) ? u_if1.busy : u_if0.busy), 64'(0));
            end
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      check_eq({tag, "_busy0"}, 64'(u_if0.busy), 0);
      check_eq({tag, "_done0"}, 64'(u_if0.done), 0);
      check_eq({tag, "_found0"}, 64'(u_if0.found), 0);
      check_eq({tag, "_seed0"}, 64'(u_if0.valid_seed), 0);
      check_eq({tag, "_att0"}, 64'(u_if0.attempts), 0);
      check_eq({tag, "_busy1"}, 64'(u_if1.busy), 0);
      check_eq({tag, "_done1"}, 64'(u_if1.done), 0);
      check_eq({tag, "_found1"}, 64'(u_if1.found), 0);
      check_eq({tag, "_seed1"}, 64'(u_if1.valid_seed), 0);
      check_eq({tag, "_att1"}, 64'(u_if1.attempts), 0);
   endtask

   task automatic set_scen(input logic [31:0] mm, input logic [31:0] lo_v, input logic [31:0] hi_v,
                           input logic [2:0] n_v, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
      m     = mm;
      a     = 32'd4001;
      c     = 32'd60211;
      lo    = lo_v;
      hi    = hi_v;
      num   = n_v;
      exp_v = {e3, e2, e1, e0};
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_all();
      int n = 0;
      while ((q0.size() + q1.size()) != 0 && n < 20000) begin
         tick();
         n++;
      end
      if ((q0.size() + q1.size()) != 0) begin
         check_eq("wait_timeout", 64'(q0.size() + q1.size()), 0);
         q0.delete();
         q1.delete();
      end
      tick();
      tick();
   endtask

   task automatic run();
      q0.push_back(model(1'b0));
      q1.push_back(model(1'b1));
      pulse_start();
      wait_all();
   endtask

   localparam logic [31:0] M = 32'd993441;

   initial begin
      repeat (3) tick();
      chk_zero("reset");
      rst_n = 1'b1;
      tick();

      set_scen(M, 0, 200, 3, 32'd444307, 32'd1777732518, 32'd242022553, 0); run();
      set_scen(M, 0, 200, 3, 32'd444307, 32'd466569, 32'd127141, 0);        run();
      set_scen(M, 0, 50, 3, 32'd444307, 32'd466569, 32'd127141, 0);         run();
      set_scen(M, 96, 96, 1, 32'd444307, 0, 0, 0);                          run();
      set_scen(M, 96, 96, 0, 32'd444307, 0, 0, 0);                          run();
      set_scen(M, 90, 100, 7, 32'd444307, 32'd1777732518, 32'd242022553, 0); run();
      set_scen(M, 100, 5, 3, 32'd444307, 32'd466569, 32'd127141, 0);        run();
      set_scen(M, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 32'd444307, 32'd466569, 0, 0); run();

      // Abort 20 cycles in: no result, no done, then a clean rerun.
      set_scen(M, 0, 200, 3, 32'd444307, 32'd1777732518, 32'd242022553, 0);
      pulse_start();
      repeat (19) tick();
      check_eq("busy_before_abort", 64'(u_if0.busy), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_eq("abort_busy0", 64'(u_if0.busy), 0);
      check_eq("abort_busy1", 64'(u_if1.busy), 0);
      check_eq("abort_found0", 64'(u_if0.found), 0);
      check_eq("abort_seed0", 64'(u_if0.valid_seed), 0);
      d0 = dn0;
      d1 = dn1;
      repeat (40) tick();
      check_eq("abort_no_done0", 64'(dn0 - d0), 0);
      check_eq("abort_no_done1", 64'(dn1 - d1), 0);

      q0.push_back(model(1'b0));
      q1.push_back(model(1'b1));
      pulse_start();
      repeat (10) tick();
      lo    = 32'd150;
      a     = 32'd7;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_all();

      // Reset mid-search clears everything at once.
      set_scen(M, 0, 50, 3, 32'd444307, 32'd466569, 32'd127141, 0);
      pulse_start();
      repeat (30) tick();
      q0.delete();
      q1.delete();
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      set_scen(M, 96, 96, 1, 32'd444307, 0, 0, 0);
      run();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
